// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with a runtime-loadable pattern,
// selectable overlapping detection and a saturating match counter.
module seq_detect_param #(
  parameter int                 PAT_W   = 4,
  parameter int                 CNT_W   = 8,
  parameter logic [PAT_W-1:0]   RST_PAT = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  generate
    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
      $error("seq_detect_param: PAT_W must be in 2..16");
    end
  endgenerate

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic              overlap_q, overlap_d;
  logic              out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;

  logic [PAT_W-1:0]  shifted_s;
  logic [FILL_W-1:0] fill_inc_s;
  logic              match_s;

  // Next-state logic: shift history, track fill, detect match, update counter
  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    pattern_d  = pattern_q;
    overlap_d  = overlap_q;
    cnt_d      = cnt_q;
    shifted_s  = {hist_q[PAT_W-2:0], in};
    fill_inc_s = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
    match_s    = in_valid && !cfg_load && (fill_inc_s == FILL_MAX) &&
                 (shifted_s == pattern_q);

    // A config load flushes all partial progress and drops the same-cycle bit
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d = shifted_s;
      fill_d = (match_s && !overlap_q) ? '0 : fill_inc_s;
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end

    out_d = match_s;

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    sat_d = (cnt_d == CNT_MAX);
  end

  // All detector state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= RST_PAT;
      overlap_q <= 1'b1;
      out_q     <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed, table-driven bench for seq_detect_param; a second instance with
// CNT_W=2 exercises counter saturation.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic       cnt_clr;

  logic       out_a, sat_a;
  logic [7:0] cnt_a;
  logic       out_b, sat_b;
  logic [1:0] cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .CNT_W(8), .RST_PAT(4'b1011)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_detect_param #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1011)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  typedef struct packed {
    logic       vld;
    logic       b;
    logic       ld;
    logic [3:0] pat;
    logic       ov;
    logic       clr;
    logic       e_out;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic vld, input logic b, input logic ld,
                             input logic [3:0] pat, input logic ov, input logic clr,
                             input logic e_out, input logic [7:0] e_cnt);
    vec_t r;
    r.vld = vld; r.b = b; r.ld = ld; r.pat = pat; r.ov = ov; r.clr = clr;
    r.e_out = e_out; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 4'b0000; cfg_overlap = 1'b0; cnt_clr = 1'b0;
  endtask

  // Present one valid bit at the falling edge, sample just after the rising edge
  task automatic send(input logic b, input logic clr);
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1; in_bit = b; cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_cnt_b;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out", {31'd0, out_a}, 32'd0);
    check("reset_cnt", {24'd0, cnt_a}, 32'd0);
    check("reset_sat", {31'd0, sat_a}, 32'd0);

    // Test 1: 1011 from reset, overlap on
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd1));
    // Test 2: flush + clear, then 1011011 overlapping -> two pulses
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 8'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd1));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd2));
    // Test 3: non-overlapping, 1011011 -> one pulse
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 8'd2));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd3));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3));
    // Test 4: 1,0, three idle cycles (in=1 ignored), 1,1
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 8'd3));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3));
    vecs.push_back(v(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd3));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd4));
    // Test 6: 1,0,1 then load 0110 with a valid 1 (dropped), then 0110
    vecs.push_back(v(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 8'd4));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd4));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd4));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd4));
    vecs.push_back(v(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 8'd4));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd4));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd4));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd4));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'd5));
    // The dropped load bit must not count toward fill: 1,1,0 alone is short
    vecs.push_back(v(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 8'd5));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd5));
    vecs.push_back(v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd5));
    vecs.push_back(v(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd5));

    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = vecs[i].vld; in_bit = vecs[i].b; cfg_load = vecs[i].ld;
      cfg_pattern = vecs[i].pat; cfg_overlap = vecs[i].ov; cnt_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out", i), {31'd0, out_a}, {31'd0, vecs[i].e_out});
      check($sformatf("vec%0d_cnt", i), {24'd0, cnt_a}, {24'd0, vecs[i].e_cnt});
    end

    // Test 4b: asynchronous reset mid-stream while out is high
    @(negedge clk);
    idle_inputs();
    cfg_load = 1'b1; cfg_pattern = 4'b1011; cfg_overlap = 1'b1;
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    check("pre_rst_out", {31'd0, out_a}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", {31'd0, out_a}, 32'd0);
    check("async_rst_cnt", {24'd0, cnt_a}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    // Stale history 1011 + 0,1,1 would rematch; a clean start must not
    send(1'b0, 1'b0);
    check("post_rst_b1", {31'd0, out_a}, 32'd0);
    send(1'b1, 1'b0);
    check("post_rst_b2", {31'd0, out_a}, 32'd0);
    send(1'b1, 1'b0);
    check("post_rst_b3", {31'd0, out_a}, 32'd0);

    // Test 5: CNT_W=2 instance, pattern 1111 overlapping, saturation
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cfg_load = 1'b1; cfg_pattern = 4'b1111; cfg_overlap = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(1'b1, 1'b0);
      exp_cnt_b = (k < 4) ? 2'd0 : ((k - 3 > 3) ? 2'd3 : 2'(k - 3));
      check($sformatf("sat_b%0d_out", k), {31'd0, out_b}, (k >= 4) ? 32'd1 : 32'd0);
      check($sformatf("sat_b%0d_cnt", k), {30'd0, cnt_b}, {30'd0, exp_cnt_b});
      check($sformatf("sat_b%0d_sat", k), {31'd0, sat_b}, (k >= 6) ? 32'd1 : 32'd0);
    end
    send(1'b1, 1'b1);
    check("clr_match_out", {31'd0, out_b}, 32'd1);
    check("clr_match_cnt", {30'd0, cnt_b}, 32'd0);
    check("clr_match_sat", {31'd0, sat_b}, 32'd0);
    check("clr_match_cnt8", {24'd0, cnt_a}, 32'd0);
    send(1'b1, 1'b0);
    check("after_clr_cnt", {30'd0, cnt_b}, 32'd1);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    check("idle_out_low", {31'd0, out_b}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector; successor to the fixed-pattern single-bit detector used in the hw2 labs.
- Samples one serial bit per qualified clock and compares the last PAT_W bits against a runtime-loadable pattern.
- Selectable overlapping or non-overlapping detection.
- Keeps a saturating count of matches; sits between a serial bit source and a status/LED or register readout.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..16).
- CNT_W, 8, width of the match counter.
- RST_PAT, 4'b1011, pattern value loaded at reset; must be PAT_W bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies `in`; a bit is consumed only when in_valid=1.
- in  input  1  serial data bit; oldest bit is shifted toward MSB.
- cfg_load  input  1  one-cycle strobe that loads cfg_pattern and cfg_overlap.
- cfg_pattern  input  PAT_W  new pattern; MSB is the first bit of the sequence.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_cnt.
- out  output  1  registered one-cycle match pulse.
- match_cnt  output  CNT_W  saturating number of matches.
- cnt_sat  output  1  high while match_cnt equals all-ones.

Behaviour:
- Reset (async, rst=1):
  - Internal state: hist=0, fill=0, pattern=RST_PAT, overlap=1.
  - Outputs: out=0, match_cnt=0, cnt_sat=0.
- Internal state:
  - hist: PAT_W-bit shift register.
  - fill: counter 0..PAT_W, saturates at PAT_W; counts valid bits received since last flush.
  - pattern, overlap: config registers.
- Accepted bit (in_valid=1, cfg_load=0):
  - next_hist = {hist[PAT_W-2:0], in}.
  - next_fill = min(fill+1, PAT_W).
- Match condition: evaluated on an accepted bit; true when next_fill==PAT_W and next_hist==pattern.
  - On the clock edge that samples the completing bit, out is registered to 1. Latency is one clock: out is visible in the cycle after the bit was presented.
  - out=0 in every cycle with no match, including in_valid=0 cycles.
- After a match:
  - overlap=1: hist and fill update normally, so a trailing prefix of the current match can start the next one.
  - overlap=0: fill is forced to 0 on that edge. hist is still updated but is ignored until PAT_W fresh bits arrive.
- in_valid=0: hist, fill and out hold, except out, which returns to 0.
- cfg_load=1:
  - pattern <= cfg_pattern, overlap <= cfg_overlap, hist <= 0, fill <= 0, out <= 0.
  - Any in bit in the same cycle is discarded, even with in_valid=1.
- match_cnt:
  - Increments by 1 on each match edge. It updates on the same edge as out, so the count is visible together with the pulse.
  - Saturates at 2^CNT_W-1. cnt_sat is registered and equals (match_cnt == all-ones).
- cnt_clr=1: match_cnt <= 0 on that edge.
  - If a match occurs in the same cycle, clear wins: match_cnt=0, but out still pulses.
  - cfg_load does not affect match_cnt.
- Reset mid-sequence: all partial progress is lost. After rst falls, PAT_W new valid bits are needed before any match.
- Parameter range: PAT_W outside 2..16 is an elaboration error.
- Target size: roughly 150 lines of RTL, with all state in one sequential block plus next-state logic.

Test Plan:
1. Reset, then stream 1,0,1,1 with in_valid=1 every cycle (PAT_W=4, RST_PAT=1011) -> out=1 exactly one cycle after the 4th bit; match_cnt=1.
2. overlap=1 (reset default), stream 1,0,1,1,0,1,1 -> out pulses after bits 4 and 7; match_cnt=2.
3. cfg_load with cfg_pattern=1011 and cfg_overlap=0, then stream 1,0,1,1,0,1,1 -> a single pulse after bit 4; match_cnt increments by 1 only.
4. Stream 1,0 then in_valid=0 for 3 cycles, then 1,1 -> out=1 after the final bit and no pulse during the idle cycles; then assert rst mid-stream after 1,0,1 -> out=0 and match_cnt=0 immediately (asynchronous).
5. CNT_W=2, produce 5 matches with overlap=1 on 1111 using a 1-bit stream -> match_cnt goes 1,2,3,3,3; cnt_sat=1 from the 3rd match. Then cnt_clr coincident with a match -> match_cnt=0 and out=1.
6. cfg_load asserted together with in_valid=1 mid-pattern (after 1,0,1), new pattern 0110 -> no pulse. Then stream 0,1,1,0 -> pulse after the 4th bit, confirming the history was flushed and the loaded bit was dropped.
